// File: rtl/y_stream_monitor.sv
`default_nettype none
// ============================================================================
// Module   : y_stream_monitor
// Purpose  : Serial-stream monitor with an overlapping 4-bit pattern detector,
//            a saturating match counter and an 8-bit MSB-first deserializer.
// Revision : 1.0 - initial release
// ============================================================================
module y_stream_monitor #(
  parameter logic [3:0] PATTERN = 4'b1101,
  parameter int         CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic             din,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic [7:0]       word,
  output logic             word_valid
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_ARMED = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       r_fill;
  logic [3:0]       r_hist;
  logic [2:0]       r_bitcnt;
  logic [7:0]       r_shift;
  logic [7:0]       r_word;
  logic             r_word_valid;
  logic             r_match;
  logic [CNT_W-1:0] r_match_count;

  logic [3:0]       w_hist_next;
  logic [7:0]       w_shift_next;
  logic             w_armed_next;
  logic             w_match;
  logic             w_word_done;

  assign w_hist_next  = {r_hist[2:0], din};
  assign w_shift_next = {r_shift[6:0], din};
  // The 4th sample arrives while in FILL with three samples already counted.
  assign w_armed_next = (r_state == ST_ARMED) ||
                        ((r_state == ST_FILL) && (r_fill == 2'd3));
  assign w_match      = en && w_armed_next && (w_hist_next == PATTERN);
  assign w_word_done  = en && (r_bitcnt == 3'd7);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_EMPTY;
      r_fill        <= 2'd0;
      r_hist        <= 4'd0;
      r_bitcnt      <= 3'd0;
      r_shift       <= 8'd0;
      r_word        <= 8'd0;
      r_word_valid  <= 1'b0;
      r_match       <= 1'b0;
      r_match_count <= '0;
    end else if (clear) begin
      r_state       <= ST_EMPTY;
      r_fill        <= 2'd0;
      r_hist        <= 4'd0;
      r_bitcnt      <= 3'd0;
      r_shift       <= 8'd0;
      r_word        <= 8'd0;
      r_word_valid  <= 1'b0;
      r_match       <= 1'b0;
      r_match_count <= '0;
    end else begin
      r_match      <= w_match;
      r_word_valid <= w_word_done;
      if (w_match && (r_match_count != {CNT_W{1'b1}})) begin
        r_match_count <= r_match_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (en) begin
        r_hist   <= w_hist_next;
        r_shift  <= w_shift_next;
        r_bitcnt <= r_bitcnt + 3'd1;
        if (w_word_done) begin
          r_word <= w_shift_next;
        end
        case (r_state)
          ST_EMPTY: begin
            r_state <= ST_FILL;
            r_fill  <= 2'd1;
          end
          ST_FILL: begin
            if (r_fill == 2'd3) begin
              r_state <= ST_ARMED;
            end else begin
              r_fill <= r_fill + 2'd1;
            end
          end
          ST_ARMED: r_state <= ST_ARMED;
          default:  r_state <= ST_EMPTY;
        endcase
      end
    end
  end

  assign match       = r_match;
  assign match_count = r_match_count;
  assign word        = r_word;
  assign word_valid  = r_word_valid;

endmodule
`default_nettype wire

// File: tb/tb_y_stream_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_y_stream_monitor
// Purpose  : Self-checking bench: directed vector table, corner-case sequences
//            and randomized traffic against a sample-history reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_y_stream_monitor;

  localparam logic [3:0] PAT = 4'b1101;
  localparam int         CW  = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          clear = 1'b0;
  logic          en = 1'b0;
  logic          din = 1'b0;
  logic          match;
  logic [CW-1:0] match_count;
  logic [7:0]    word;
  logic          word_valid;

  y_stream_monitor #(.PATTERN(PAT), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .clear(clear), .en(en), .din(din),
    .match(match), .match_count(match_count), .word(word),
    .word_valid(word_valid)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the list of samples taken since the last flush.
  bit   q[$];
  int   nsamp;
  logic m_match, m_wv;
  int   m_cnt;
  logic [7:0] m_word;

  typedef struct {
    bit clr; bit e; bit d;
    bit em; bit ewv; int ecnt; logic [7:0] eword;
  } vec_t;
  vec_t tv[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] last_bits(input int k);
    logic [7:0] v = 8'd0;
    for (int i = 0; i < k; i++) v = {v[6:0], q[q.size()-k+i]};
    return v;
  endfunction

  task automatic model_flush();
    q.delete();
    nsamp = 0; m_match = 0; m_wv = 0; m_cnt = 0; m_word = 8'd0;
  endtask

  task automatic model_edge(input bit c, input bit e, input bit d);
    if (c) begin
      model_flush();
    end else if (e) begin
      q.push_back(d);
      nsamp++;
      m_match = (q.size() >= 4) && (last_bits(4) == {4'd0, PAT});
      if (m_match && m_cnt < (1 << CW) - 1) m_cnt++;
      m_wv = (nsamp % 8 == 0);
      if (m_wv) m_word = last_bits(8);
    end else begin
      m_match = 0; m_wv = 0;
    end
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".match"}, 32'(match), 32'(m_match));
    check({tag, ".word_valid"}, 32'(word_valid), 32'(m_wv));
    check({tag, ".match_count"}, 32'(match_count), 32'(m_cnt));
    check({tag, ".word"}, 32'(word), 32'(m_word));
  endtask

  task automatic step(input bit c, input bit e, input bit d, input string tag);
    clear = c; en = e; din = d;
    @(posedge clk);
    #1;
    model_edge(c, e, d);
    compare_model(tag);
  endtask

  task automatic add(input bit c, input bit e, input bit d, input bit em,
                     input bit ewv, input int ecnt, input logic [7:0] ew);
    vec_t v;
    v.clr = c; v.e = e; v.d = d; v.em = em; v.ewv = ewv; v.ecnt = ecnt; v.eword = ew;
    tv.push_back(v);
  endtask

  // Reset asserted between edges; outputs must drop before the next edge.
  task automatic async_reset(input string tag);
    #2 reset = 1'b1;
    #1;
    model_flush();
    compare_model(tag);
    #1 reset = 1'b0;
  endtask

  initial begin
    model_flush();
    #2;
    compare_model("reset");
    #10 reset = 1'b0;

    // Basic 1101 detection
    add(1,0,0, 0,0,0,8'h00);
    add(0,1,1, 0,0,0,8'h00); add(0,1,1, 0,0,0,8'h00);
    add(0,1,0, 0,0,0,8'h00); add(0,1,1, 1,0,1,8'h00);
    add(0,0,0, 0,0,1,8'h00);
    // Overlapping matches: 1101101
    add(1,0,0, 0,0,0,8'h00);
    add(0,1,1, 0,0,0,8'h00); add(0,1,1, 0,0,0,8'h00); add(0,1,0, 0,0,0,8'h00);
    add(0,1,1, 1,0,1,8'h00); add(0,1,1, 0,0,1,8'h00); add(0,1,0, 0,0,1,8'h00);
    add(0,1,1, 1,0,2,8'h00);
    // Deserializer: 10110010 -> B2
    add(1,0,0, 0,0,0,8'h00);
    add(0,1,1, 0,0,0,8'h00); add(0,1,0, 0,0,0,8'h00); add(0,1,1, 0,0,0,8'h00);
    add(0,1,1, 0,0,0,8'h00); add(0,1,0, 0,0,0,8'h00); add(0,1,0, 0,0,0,8'h00);
    add(0,1,1, 0,0,0,8'h00); add(0,1,0, 0,1,0,8'hB2);
    add(0,0,0, 0,0,0,8'hB2); add(0,1,1, 0,0,0,8'hB2);
    // 110, clear, then 1: no match; 1101 after the clear then matches
    add(1,0,0, 0,0,0,8'h00);
    add(0,1,1, 0,0,0,8'h00); add(0,1,1, 0,0,0,8'h00); add(0,1,0, 0,0,0,8'h00);
    add(1,0,0, 0,0,0,8'h00); add(0,1,1, 0,0,0,8'h00);
    add(0,1,1, 0,0,0,8'h00); add(0,1,0, 0,0,0,8'h00); add(0,1,1, 1,0,1,8'h00);
    // Gapped samples; din during en=0 must be ignored
    add(1,0,0, 0,0,0,8'h00);
    add(0,1,1, 0,0,0,8'h00); add(0,0,0, 0,0,0,8'h00); add(0,1,1, 0,0,0,8'h00);
    add(0,0,0, 0,0,0,8'h00); add(0,1,0, 0,0,0,8'h00); add(0,1,1, 1,0,1,8'h00);

    for (int i = 0; i < tv.size(); i++) begin
      step(tv[i].clr, tv[i].e, tv[i].d, $sformatf("vec%0d", i));
      check($sformatf("vec%0d.tbl_match", i), 32'(match), 32'(tv[i].em));
      check($sformatf("vec%0d.tbl_wv", i), 32'(word_valid), 32'(tv[i].ewv));
      check($sformatf("vec%0d.tbl_cnt", i), 32'(match_count), 32'(tv[i].ecnt));
      check($sformatf("vec%0d.tbl_word", i), 32'(word), 32'(tv[i].eword));
    end

    // Saturation: 1,1,0 repeated matches every 3 samples after the 4th
    step(1, 0, 0, "sat_clr");
    for (int i = 0; i < 800; i++) step(0, 1, (i % 3) != 2, "sat_fill");
    while (m_cnt < 255) step(0, 1, (nsamp % 3) != 2, "sat_top");
    check("sat_cnt_full", 32'(match_count), 32'd255);
    while (!(q[q.size()-1] == 1 && q[q.size()-2] == 1)) step(0, 1, (nsamp % 3) != 2, "sat_align");
    step(0, 1, 0, "sat_last0");
    step(0, 1, 1, "sat_last1");
    check("sat_extra_match", 32'(match), 32'd1);
    check("sat_hold", 32'(match_count), 32'd255);

    // Gapped 1,1 then async reset, then 0,1: nothing detected
    step(0, 1, 1, "rst_s1");
    for (int i = 0; i < 3; i++) step(0, 0, 0, "rst_gap");
    step(0, 1, 1, "rst_s2");
    for (int i = 0; i < 3; i++) step(0, 0, 0, "rst_gap");
    async_reset("rst_async");
    check("rst_cnt_zero", 32'(match_count), 32'd0);
    step(0, 1, 0, "rst_s3");
    step(0, 1, 1, "rst_s4");
    check("rst_no_match", 32'(match), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      bit c, e, d;
      c = ($urandom_range(0, 99) < 3);
      e = ($urandom_range(0, 99) < 75);
      d = 1'($urandom);
      step(c, e, d, "rand");
      if ($urandom_range(0, 199) == 0) async_reset("rand_rst");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
